// File: rtl/mips_cpu_bus_muldiv_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Multiply is radix-2 shift-add, divide is restoring; both run on magnitudes
// and fix up signs in a dedicated SIGN cycle before HI/LO are written.
// Optional build macro: MULDIV_EARLY_OUT_EN lets multiplies leave CALC as soon
// as the remaining multiplier bits are all zero (divide timing unchanged).
module mips_cpu_bus_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [4:0]       control_alu,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [4:0] OP_DIVU  = 5'd4;
  localparam logic [4:0] OP_DIV   = 5'd5;
  localparam logic [4:0] OP_MULTU = 5'd7;
  localparam logic [4:0] OP_MULT  = 5'd8;
  localparam logic [4:0] OP_MTLO  = 5'd18;
  localparam logic [4:0] OP_MTHI  = 5'd19;
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_SIGN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] p_q, p_d;    // mult: product; div: {remainder, quotient}
  logic [2*WIDTH-1:0] a_q, a_d;    // mult: multiplicand shifted left each step
  logic [WIDTH-1:0]   b_q, b_d;    // mult: multiplier shifted right; div: divisor
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               div_q, div_d;
  logic               negq_q, negq_d;  // negate product / quotient
  logic               negr_q, negr_d;  // negate remainder
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

  // Request decode; only meaningful while IDLE
  logic             is_div, is_md, signed_op, div_zero, accept_md, calc_exit;
  logic [WIDTH-1:0] abs_a, abs_b;
  assign is_div    = (control_alu == OP_DIV) || (control_alu == OP_DIVU);
  assign is_md     = is_div || (control_alu == OP_MULT) || (control_alu == OP_MULTU);
  assign signed_op = (control_alu == OP_DIV) || (control_alu == OP_MULT);
  assign div_zero  = is_div && (op_b == '0);
  assign abs_a     = (signed_op && op_a[WIDTH-1]) ? -op_a : op_a;
  assign abs_b     = (signed_op && op_b[WIDTH-1]) ? -op_b : op_b;
  assign accept_md = (state_q == S_IDLE) && start && is_md;

  // Restoring-divide step: shift one dividend bit into the partial remainder
  logic [WIDTH:0]   trial, diff;
  logic             ge;
  logic [WIDTH-1:0] rem_new;
  assign trial   = p_q[2*WIDTH-1:WIDTH-1];
  assign ge      = trial >= {1'b0, b_q};
  assign diff    = trial - {1'b0, b_q};
  assign rem_new = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];

  // Sign fix-up results
  logic [2*WIDTH-1:0] prod_fix;
  assign prod_fix = negq_q ? -p_q : p_q;

`ifdef MULDIV_EARLY_OUT_EN
  assign calc_exit = (cnt_q == CW'(WIDTH-1)) || (!div_q && (b_q[WIDTH-1:1] == '0));
`else
  assign calc_exit = (cnt_q == CW'(WIDTH-1));
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept_md) state_d = div_zero ? S_DONE : S_CALC;
      S_CALC: if (calc_exit) state_d = S_SIGN;
      S_SIGN: state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy = (state_q == S_CALC) || (state_q == S_SIGN);
    done = (state_q == S_DONE);
  end

  // Datapath next-state: load on acceptance, iterate in CALC, fix signs in SIGN
  always_comb begin
    p_d = p_q; a_d = a_q; b_d = b_q; cnt_d = cnt_q;
    div_d = div_q; negq_d = negq_q; negr_d = negr_q;
    hi_d = hi_q; lo_d = lo_q;
    case (state_q)
      S_IDLE: if (start) begin
        if (control_alu == OP_MTHI)      hi_d = op_a;
        else if (control_alu == OP_MTLO) lo_d = op_a;
        else if (is_md) begin
          cnt_d  = '0;
          div_d  = is_div;
          negq_d = signed_op && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
          negr_d = signed_op && op_a[WIDTH-1];
          b_d    = abs_b;
          if (div_zero) begin
            hi_d = op_a;
            lo_d = '1;
          end else if (is_div) begin
            p_d = {{WIDTH{1'b0}}, abs_a};
            a_d = '0;
          end else begin
            p_d = '0;
            a_d = {{WIDTH{1'b0}}, abs_a};
          end
        end
      end
      S_CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (div_q) begin
          p_d = {rem_new, p_q[WIDTH-2:0], ge};
        end else begin
          if (b_q[0]) p_d = p_q + a_q;
          a_d = a_q << 1;
          b_d = b_q >> 1;
        end
      end
      S_SIGN: begin
        if (div_q) begin
          lo_d = negq_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
          hi_d = negr_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q <= '0; a_q <= '0; b_q <= '0; cnt_q <= '0;
      div_q <= 1'b0; negq_q <= 1'b0; negr_q <= 1'b0;
      hi_q <= '0; lo_q <= '0;
    end else begin
      p_q <= p_d; a_q <= a_d; b_q <= b_d; cnt_q <= cnt_d;
      div_q <= div_d; negq_q <= negq_d; negr_q <= negr_d;
      hi_q <= hi_d; lo_q <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_mips_cpu_bus_muldiv_unit.sv
// Self-checking bench for mips_cpu_bus_muldiv_unit (default build).
// Expected HI/LO pairs are pushed to a scoreboard queue when an operation is
// issued and popped when done is observed.
module tb_mips_cpu_bus_muldiv_unit;

  localparam logic [4:0] C_DIVU = 5'd4, C_DIV = 5'd5, C_MULTU = 5'd7, C_MULT = 5'd8;
  localparam logic [4:0] C_MTLO = 5'd18, C_MTHI = 5'd19;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  control_alu = '0;
  logic [31:0] op_a = '0, op_b = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int vectors = 0;
  int errors  = 0;
  logic [63:0] sb[$];

  mips_cpu_bus_muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .control_alu(control_alu),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Reference model for the four arithmetic ops, {hi, lo}
  function automatic logic [63:0] model(input logic [4:0] c, input logic [31:0] a, b);
    longint sa, sb_, q, r;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a)); sb_ = longint'($signed(b));
    ua = {32'd0, a}; ub = {32'd0, b};
    case (c)
      C_MULTU: p = ua * ub;
      C_MULT:  p = 64'(sa * sb_);
      C_DIVU:  p = {32'(ua % ub), 32'(ua / ub)};
      default: begin q = sa / sb_; r = sa % sb_; p = {32'(r), 32'(q)}; end
    endcase
    return p;
  endfunction

  // Drive one request and wait (bounded) for done. edges = clock edges after
  // the accepting edge until done is seen; returns one cycle after done.
  task automatic issue(input logic [4:0] c, input logic [31:0] a, b,
                       output int edges, output int bcnt, output logic bfirst,
                       output logic bdone);
    start = 1'b1; control_alu = c; op_a = a; op_b = b;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 0; bcnt = 0; bfirst = busy;
    while (done !== 1'b1 && edges < 100) begin
      if (busy === 1'b1) bcnt++;
      @(posedge clk); #1;
      edges++;
    end
    bdone = busy;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    vectors++; if (hi !== 32'd0)   begin errors++; $display("FAIL reset_hi got %h want 0", hi); end
    vectors++; if (lo !== 32'd0)   begin errors++; $display("FAIL reset_lo got %h want 0", lo); end
    vectors++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if (done !== 1'b0)  begin errors++; $display("FAIL reset_done got %b want 0", done); end
  endtask

  task automatic test_mul_div(input logic [4:0] c, input logic [31:0] a, b, input string nm);
    int e, bc; logic bf, bd; logic [63:0] exp;
    sb.push_back(model(c, a, b));
    issue(c, a, b, e, bc, bf, bd);
    vectors++; if (e !== 33) begin errors++; $display("FAIL %s_latency got %0d want 33", nm, e); end
    vectors++; if (bf !== 1'b1) begin errors++; $display("FAIL %s_busy_first got %b want 1", nm, bf); end
    vectors++; if (bd !== 1'b0) begin errors++; $display("FAIL %s_busy_at_done got %b want 0", nm, bd); end
    exp = sb.pop_front();
    vectors++; if ({hi, lo} !== exp) begin errors++; $display("FAIL %s_result got %h_%h want %h_%h", nm, hi, lo, exp[63:32], exp[31:0]); end
    vectors++; if (done !== 1'b0) begin errors++; $display("FAIL %s_done_pulse got %b want 0", nm, done); end
  endtask

  task automatic test_spec_values();
    // Fixed expectations independent of the model
    int e, bc; logic bf, bd;
    issue(C_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, e, bc, bf, bd);
    vectors++; if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin errors++; $display("FAIL multu_max got %h_%h want fffffffe_00000001", hi, lo); end
    issue(C_MULT, 32'hFFFF_FFFD, 32'd5, e, bc, bf, bd);
    vectors++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFF1) begin errors++; $display("FAIL mult_neg got %h_%h want ffffffff_fffffff1", hi, lo); end
    issue(C_DIV, 32'hFFFF_FFF9, 32'd2, e, bc, bf, bd);
    vectors++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("FAIL div_neg got %h_%h want ffffffff_fffffffd", hi, lo); end
    issue(C_DIVU, 32'd7, 32'd2, e, bc, bf, bd);
    vectors++; if ({hi, lo} !== 64'h0000_0001_0000_0003) begin errors++; $display("FAIL divu_7_2 got %h_%h want 1_3", hi, lo); end
    issue(C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, e, bc, bf, bd);
    vectors++; if ({hi, lo} !== 64'h0000_0000_8000_0000) begin errors++; $display("FAIL div_ovf got %h_%h want 0_80000000", hi, lo); end
  endtask

  task automatic test_div_zero();
    int e, bc; logic bf, bd; logic [63:0] exp;
    sb.push_back({32'h0000_1234, 32'hFFFF_FFFF});
    issue(C_DIVU, 32'h1234, 32'd0, e, bc, bf, bd);
    vectors++; if (e !== 0) begin errors++; $display("FAIL div0_latency got %0d want done right after accept", e); end
    vectors++; if (bc !== 0 || bf !== 1'b0) begin errors++; $display("FAIL div0_busy got cnt=%0d first=%b want 0", bc, bf); end
    exp = sb.pop_front();
    vectors++; if ({hi, lo} !== exp) begin errors++; $display("FAIL div0_result got %h_%h want %h_%h", hi, lo, exp[63:32], exp[31:0]); end
  endtask

  task automatic test_move();
    start = 1'b1; control_alu = C_MTLO; op_a = 32'hDEAD_BEEF;
    @(posedge clk); #1; start = 1'b0;
    vectors++; if (lo !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mtlo got %h want deadbeef", lo); end
    vectors++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mtlo_flags got done=%b busy=%b want 0 0", done, busy); end
    start = 1'b1; control_alu = C_MTHI; op_a = 32'h0BAD_F00D;
    @(posedge clk); #1; start = 1'b0;
    vectors++; if (hi !== 32'h0BAD_F00D) begin errors++; $display("FAIL mthi got %h want 0badf00d", hi); end
    // Unknown code: no effect
    start = 1'b1; control_alu = 5'd9; op_a = 32'h1111_1111;
    @(posedge clk); #1; start = 1'b0;
    vectors++; if ({hi, lo, busy, done} !== {32'h0BAD_F00D, 32'hDEAD_BEEF, 2'b00}) begin errors++; $display("FAIL unknown_code got %h_%h b=%b d=%b", hi, lo, busy, done); end
  endtask

  task automatic test_mthi_during_calc();
    int n; logic [63:0] exp;
    sb.push_back(model(C_MULTU, 32'd2, 32'd3));
    start = 1'b1; control_alu = C_MULTU; op_a = 32'd2; op_b = 32'd3;
    @(posedge clk); #1;
    control_alu = C_MTHI; op_a = 32'hAAAA_AAAA;
    repeat (3) @(posedge clk); #1;
    start = 1'b0;
    vectors++; if (hi !== 32'h0BAD_F00D) begin errors++; $display("FAIL mthi_in_calc got %h want 0badf00d", hi); end
    n = 0;
    while (done !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    exp = sb.pop_front();
    vectors++; if ({hi, lo} !== exp) begin errors++; $display("FAIL mthi_calc_result got %h_%h want %h_%h", hi, lo, exp[63:32], exp[31:0]); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    // Start held high: ignored in DONE, accepted once back in IDLE
    start = 1'b1; control_alu = C_DIVU; op_a = 32'h77; op_b = 32'd0;
    @(posedge clk); #1;
    control_alu = C_MTLO; op_a = 32'h5555;
    @(posedge clk); #1;
    vectors++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL start_in_done got lo=%h want ffffffff", lo); end
    @(posedge clk); #1; start = 1'b0;
    vectors++; if (lo !== 32'h5555) begin errors++; $display("FAIL start_after_done got lo=%h want 5555", lo); end
  endtask

  task automatic test_random();
    logic [4:0] codes[4];
    codes = '{C_MULTU, C_MULT, C_DIVU, C_DIV};
    for (int i = 0; i < 8; i++) begin
      logic [31:0] a, b;
      a = $urandom; b = $urandom;
      if (i >= 4) b = b >> $urandom_range(31, 0);
      if (b == 0) b = 32'd13;
      test_mul_div(codes[i % 4], a, b, "rand");
    end
  endtask

  task automatic test_mid_reset();
    int e, bc; logic bf, bd; logic [63:0] exp;
    start = 1'b1; control_alu = C_MULTU; op_a = 32'hFFFF; op_b = 32'hFFFF;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0; #1;
    vectors++; if ({hi, lo} !== 64'd0) begin errors++; $display("FAIL midreset_hilo got %h_%h want 0_0", hi, lo); end
    vectors++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midreset_flags got b=%b d=%b want 0 0", busy, done); end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      vectors++; if (done !== 1'b0) begin errors++; $display("FAIL midreset_no_done got %b want 0", done); end
    end
    sb.push_back({32'd0, 32'd12});
    issue(C_MULTU, 32'd3, 32'd4, e, bc, bf, bd);
    exp = sb.pop_front();
    vectors++; if ({hi, lo} !== exp) begin errors++; $display("FAIL post_reset_mul got %h_%h want %h_%h", hi, lo, exp[63:32], exp[31:0]); end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_mul_div(C_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu");
    test_mul_div(C_MULT, 32'hFFFF_FFFD, 32'd5, "mult");
    test_mul_div(C_DIV, 32'hFFFF_FFF9, 32'd2, "div");
    test_mul_div(C_DIVU, 32'd7, 32'd2, "divu");
    test_spec_values();
    test_div_zero();
    test_move();
    test_mthi_during_calc();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
